// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit scheduling blocks.
package uart_pkg;
   localparam int MSG_W  = 16;
   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      SEND_HI,
      WAIT_HI,
      SEND_LO,
      WAIT_LO,
      GAP
   } sched_state_t;
endpackage

// File: rtl/Counter.sv
// Loadable up/down counter; load has priority over enable, wraps freely.
module Counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic         up_i,
   output logic [W-1:0] count_o
);
   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i)
         count_d = load_val_i;
      else if (en_i)
         count_d = up_i ? count_q + W'(1) : count_q - W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count_o = count_q;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 3
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o,
   output logic          any_o
);
   int   j;
   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr_i) + i) % N;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = PW'(j);
         end
      end
      any_o = found;
   end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shares one byte UART among NUM_REQ requesters, sending each 16-bit
// message high byte first; tx_start follows grant by one cycle, then an idle gap.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int GAP_CYCLES = 16,
   parameter int GAP_W      = 8
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [MSG_W*NUM_REQ-1:0] msg_i,
   output logic [NUM_REQ-1:0]       ack_o,
   output logic [BYTE_W-1:0]        tx_data_o,
   output logic                     tx_start_o,
   input  logic                     tx_busy_i,
   output logic [2:0]               grant_id_o,
   output logic                     busy_o
);
   sched_state_t       state_q, state_d;
   logic [2:0]         rr_ptr_q, rr_ptr_d;
   logic [MSG_W-1:0]   hold_q, hold_d;
   logic [2:0]         grant_id_q, grant_id_d;
   logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
   logic               seen_busy_q, seen_busy_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [2:0]         arb_idx;
   logic               arb_any;
   logic               gap_load, gap_en;
   logic [GAP_W-1:0]   gap_cnt;

   rr_arbiter #(.N(NUM_REQ), .PW(3)) u_arb (
      .req_i (req_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   Counter #(.W(GAP_W)) u_gap (
      .clk_i      (clock_i),
      .rst_i      (reset_i),
      .load_i     (gap_load),
      .load_val_i (GAP_W'(GAP_CYCLES - 1)),
      .en_i       (gap_en),
      .up_i       (1'b0),
      .count_o    (gap_cnt)
   );

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      hold_d      = hold_q;
      grant_id_d  = grant_id_q;
      grant_oh_d  = grant_oh_q;
      seen_busy_d = seen_busy_q;
      gap_load    = 1'b0;
      gap_en      = 1'b0;
      ack_o       = '0;
      tx_start_o  = 1'b0;
      tx_data_o   = '0;
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               hold_d     = msg_i[arb_idx*MSG_W +: MSG_W];
               grant_id_d = arb_idx;
               grant_oh_d = arb_gnt;
               state_d    = SEND_HI;
            end
         end
         SEND_HI, SEND_LO: begin
            tx_data_o = (state_q == SEND_HI) ? hold_q[MSG_W-1:BYTE_W] : hold_q[BYTE_W-1:0];
            if (!tx_busy_i) begin
               tx_start_o = 1'b1;
               state_d    = (state_q == SEND_HI) ? WAIT_HI : WAIT_LO;
            end
         end
         WAIT_HI, WAIT_LO: begin
            // A frame is finished only after busy has been seen high and then low.
            if (!seen_busy_q) begin
               seen_busy_d = tx_busy_i;
            end else if (!tx_busy_i) begin
               seen_busy_d = 1'b0;
               if (state_q == WAIT_HI) begin
                  state_d = SEND_LO;
               end else begin
                  ack_o    = grant_oh_q;
                  gap_load = 1'b1;
                  rr_ptr_d = (grant_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
                  state_d  = GAP;
               end
            end
         end
         GAP: begin
            if (gap_cnt == '0)
               state_d = IDLE;
            else
               gap_en = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // A reset cycle must never launch a byte or acknowledge a message.
      if (reset_i) begin
         ack_o      = '0;
         tx_start_o = 1'b0;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         hold_q      <= '0;
         grant_id_q  <= '0;
         grant_oh_q  <= '0;
         seen_busy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         hold_q      <= hold_d;
         grant_id_q  <= grant_id_d;
         grant_oh_q  <= grant_oh_d;
         seen_busy_q <= seen_busy_d;
      end
   end

   assign grant_id_o = grant_id_q;
   assign busy_o     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a fixed-length transmitter model.
module tb_uart_tx_scheduler;
   localparam int NUM_REQ    = 4;
   localparam int GAP_CYCLES = 16;
   localparam int GAP_W      = 8;
   localparam int TXB        = 10;
   localparam int HI_TO_LO   = TXB + 2;
   localparam int LO_TO_NEXT = TXB + GAP_CYCLES + 3;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_REQ-1:0]   req;
   logic [16*NUM_REQ-1:0] msg;
   logic [NUM_REQ-1:0]   ack;
   logic [7:0]           tx_data;
   logic                 tx_start;
   logic                 tx_busy;
   logic [2:0]           grant_id;
   logic                 busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int tx_cnt = 0;
   logic ext_busy = 1'b0;

   logic [7:0] bytes_q[$];
   int         start_q[$];
   int         acks_q[$];

   always #5 clk = ~clk;

   uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES), .GAP_W(GAP_W)) dut (
      .clock_i    (clk),
      .reset_i    (reset),
      .req_i      (req),
      .msg_i      (msg),
      .ack_o      (ack),
      .tx_data_o  (tx_data),
      .tx_start_o (tx_start),
      .tx_busy_i  (tx_busy),
      .grant_id_o (grant_id),
      .busy_o     (busy)
   );

   assign tx_busy = (tx_cnt != 0) || ext_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Transmitter: busy for TXB cycles starting the cycle after tx_start.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_start)
         tx_cnt <= TXB;
      else if (tx_cnt != 0)
         tx_cnt <= tx_cnt - 1;
   end

   always @(negedge clk) begin
      if (tx_start) begin
         check("start_while_busy", 32'(tx_busy), 32'd0);
         bytes_q.push_back(tx_data);
         start_q.push_back(cyc);
      end
      if (ack != '0) begin
         check("ack_onehot", 32'($countones(ack)), 32'd1);
         for (int i = 0; i < NUM_REQ; i++)
            if (ack[i]) acks_q.push_back(i);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      tick();
      tick();
      reset = 1'b0;
      bytes_q.delete();
      start_q.delete();
      acks_q.delete();
   endtask

   task automatic run_until_ack(output int idx);
      idx = -1;
      for (int n = 0; n < 400; n++) begin
         tick();
         if (ack != '0) begin
            for (int i = 0; i < NUM_REQ; i++)
               if (ack[i]) idx = i;
            break;
         end
      end
      if (idx < 0) check("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic busy_len(output int len);
      len = 0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (!busy) break;
         len++;
      end
   endtask

   initial begin
      int idx;
      int len;
      int found;

      reset = 1'b1;
      req   = '0;
      msg   = '0;
      tick();
      tick();
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      bytes_q.delete();
      start_q.delete();
      acks_q.delete();

      // 1: single request
      msg[15:0] = 16'hA55A;
      req = 4'b0001;
      #1;
      check("t1_busy_pre", 32'(busy), 32'd0);
      tick();
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_grant_id", 32'(grant_id), 32'd0);
      check("t1_start_lat", 32'(tx_start), 32'd1);
      check("t1_first_byte", 32'(tx_data), 32'hA5);
      run_until_ack(idx);
      req = '0;
      check("t1_ack_idx", 32'(idx), 32'd0);
      busy_len(len);
      check("t1_gap_len", 32'(len), 32'(GAP_CYCLES));
      check("t1_nbytes", 32'(bytes_q.size()), 32'd2);
      check("t1_byte0", 32'(bytes_q[0]), 32'hA5);
      check("t1_byte1", 32'(bytes_q[1]), 32'h5A);
      check("t1_nacks", 32'(acks_q.size()), 32'd1);
      check("t1_hi_lo", 32'(start_q[1] - start_q[0]), 32'(HI_TO_LO));

      // 2: all four at once
      do_reset();
      msg = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         run_until_ack(idx);
         check("t2_order", 32'(idx), 32'(k));
         if (idx >= 0) req[idx] = 1'b0;
      end
      busy_len(len);
      check("t2_nbytes", 32'(bytes_q.size()), 32'd8);
      for (int k = 0; k < 4; k++) begin
         check("t2_byte_hi", 32'(bytes_q[2*k]), 32'((k + 1) * 17));
         check("t2_byte_lo", 32'(bytes_q[2*k+1]), 32'((k + 1) * 17));
         check("t2_hi_lo", 32'(start_q[2*k+1] - start_q[2*k]), 32'(HI_TO_LO));
         if (k < 3)
            check("t2_msg_gap", 32'(start_q[2*k+2] - start_q[2*k+1]), 32'(LO_TO_NEXT));
      end

      // 3: fairness with req[3] held
      do_reset();
      msg[63:48] = 16'hABCD;
      req = 4'b1000;
      tick();
      tick();
      check("t3_grant3", 32'(grant_id), 32'd3);
      msg[15:0] = 16'h0102;
      req[0] = 1'b1;
      run_until_ack(idx);
      check("t3_ack_a", 32'(idx), 32'd3);
      run_until_ack(idx);
      check("t3_ack_b", 32'(idx), 32'd0);
      req[0] = 1'b0;
      run_until_ack(idx);
      check("t3_ack_c", 32'(idx), 32'd3);
      req = '0;
      busy_len(len);
      check("t3_byte2", 32'(bytes_q[2]), 32'h01);
      check("t3_byte3", 32'(bytes_q[3]), 32'h02);
      check("t3_byte4", 32'(bytes_q[4]), 32'hAB);

      // 4: transmitter already busy at grant
      do_reset();
      ext_busy = 1'b1;
      msg[15:0] = 16'hBEEF;
      req = 4'b0001;
      tick();
      check("t4_busy", 32'(busy), 32'd1);
      check("t4_held_a", 32'(tx_start), 32'd0);
      repeat (4) tick();
      check("t4_held_b", 32'(tx_start), 32'd0);
      ext_busy = 1'b0;
      #1;
      check("t4_release", 32'(tx_start), 32'd1);
      check("t4_release_dat", 32'(tx_data), 32'hBE);
      run_until_ack(idx);
      req = '0;
      check("t4_ack_idx", 32'(idx), 32'd0);
      busy_len(len);
      check("t4_byte1", 32'(bytes_q[1]), 32'hEF);

      // 5: msg changes after grant
      do_reset();
      msg[15:0] = 16'h1234;
      req = 4'b0001;
      tick();
      msg[15:0] = 16'hFFFF;
      run_until_ack(idx);
      req = '0;
      busy_len(len);
      check("t5_byte0", 32'(bytes_q[0]), 32'h12);
      check("t5_byte1", 32'(bytes_q[1]), 32'h34);

      // 6: reset during WAIT_LO
      do_reset();
      msg[15:0] = 16'h5678;
      req = 4'b0001;
      found = 0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (tx_start && tx_data == 8'h78) begin
            found = 1;
            break;
         end
      end
      check("t6_lo_seen", 32'(found), 32'd1);
      tick();
      tick();
      check("t6_busy_pre", 32'(busy), 32'd1);
      reset = 1'b1;
      req   = '0;
      tick();
      reset = 1'b0;
      check("t6_ack", 32'(ack), 32'd0);
      check("t6_tx_start", 32'(tx_start), 32'd0);
      check("t6_tx_data", 32'(tx_data), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_grant_id", 32'(grant_id), 32'd0);
      check("t6_no_ack", 32'(acks_q.size()), 32'd0);
      bytes_q.delete();
      acks_q.delete();
      msg[31:16] = 16'h9ABC;
      req = 4'b0010;
      run_until_ack(idx);
      req = '0;
      check("t6_ack_idx", 32'(idx), 32'd1);
      busy_len(len);
      check("t6_byte0", 32'(bytes_q[0]), 32'h9A);
      check("t6_byte1", 32'(bytes_q[1]), 32'hBC);
      check("t6_nacks", 32'(acks_q.size()), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
